// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module  : cpu_pkg
//  Brief   : Shared opcodes, ALU/PC codes and FSM encoding for cpu_ctrl.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LDI    = 4'b1000;
    localparam logic [3:0] OP_ADDI   = 4'b1001;
    localparam logic [3:0] OP_JMP    = 4'b1100;
    localparam logic [3:0] OP_JR     = 4'b1101;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    localparam logic [3:0] ALU_NONE  = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SHL   = 4'b0110;
    localparam logic [3:0] ALU_SHR   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1000;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_LOAD   = 2'b10;
    localparam logic [1:0] PC_REL    = 2'b11;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_NOP  = 3'd1,
        CLS_JMP  = 3'd2,
        CLS_JR   = 3'd3,
        CLS_HALT = 3'd4
    } ins_class_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_FWAIT  = 4'd2,
        ST_DECODE = 4'd3,
        ST_EXEC   = 4'd4,
        ST_AWAIT  = 4'd5,
        ST_WB     = 4'd6,
        ST_PCUPD  = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
//  Module  : ctrl_decode
//  Brief   : Combinational opcode decoder: ALU function, operand select,
//            instruction class and illegal-opcode flag.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [3:0] o_alu_func,
    output logic       o_alu_in_sel,
    output ins_class_t o_ins_class,
    output logic       o_illegal
);

    always_comb begin
        o_alu_func   = ALU_NONE;
        o_alu_in_sel = 1'b0;
        o_ins_class  = CLS_NOP;
        o_illegal    = 1'b0;
        case (i_opcode)
            OP_NOP: ;
            4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b0111: begin
                o_alu_func  = {1'b0, i_opcode[2:0]};
                o_ins_class = CLS_ALU;
            end
            OP_LDI: begin
                o_alu_func   = ALU_PASSB;
                o_alu_in_sel = 1'b1;
                o_ins_class  = CLS_ALU;
            end
            OP_ADDI: begin
                o_alu_func   = ALU_ADD;
                o_alu_in_sel = 1'b1;
                o_ins_class  = CLS_ALU;
            end
            OP_JMP:  o_ins_class = CLS_JMP;
            OP_JR:   o_ins_class = CLS_JR;
            OP_HALT: o_ins_class = CLS_HALT;
            // Illegal opcodes fall through as a NOP with the flag raised
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ============================================================================
//  Module  : cpu_ctrl
//  Brief   : Fetch/decode/execute sequencer driving the 16-bit datapath.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       ins_req,
    input  logic       ins_valid,
    input  logic [15:0] ins,
    input  logic       alu_done,
    output logic       en_in_rf,
    output logic [3:0] reg_en,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output logic       alu_in_sel,
    output logic [3:0] alu_func,
    output logic [7:0] offset,
    output logic       en_pc_pulse,
    output logic [1:0] pc_ctrl,
    output logic [7:0] offset_addr,
    output logic       busy,
    output logic       halted,
    output logic       fault
);

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [15:0] r_ir;
    logic [7:0] r_cnt;
    logic       r_fault;
    logic [1:0] r_rd;
    logic [1:0] r_rs;
    logic [3:0] r_alu_func;
    logic       r_alu_in_sel;
    logic [7:0] r_imm;
    logic [1:0] r_pc_op;

    logic [3:0] w_alu_func;
    logic       w_alu_in_sel;
    ins_class_t w_cls;
    logic       w_illegal;
    logic       w_tmo;

    ctrl_decode u_decode (
        .i_opcode     (r_ir[15:12]),
        .o_alu_func   (w_alu_func),
        .o_alu_in_sel (w_alu_in_sel),
        .o_ins_class  (w_cls),
        .o_illegal    (w_illegal)
    );

    assign w_tmo = (r_cnt >= c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_FWAIT;
            ST_FWAIT: begin
                if (ins_valid)  w_next = ST_DECODE;
                else if (w_tmo) w_next = ST_HALT;
            end
            ST_DECODE: begin
                case (w_cls)
                    CLS_ALU:  w_next = ST_EXEC;
                    CLS_HALT: w_next = ST_HALT;
                    default:  w_next = ST_PCUPD;
                endcase
            end
            ST_EXEC:   w_next = ST_AWAIT;
            // A completion on the terminal count wins over the timeout
            ST_AWAIT: begin
                if (alu_done)   w_next = ST_WB;
                else if (w_tmo) w_next = ST_HALT;
            end
            ST_WB:     w_next = ST_PCUPD;
            ST_PCUPD:  w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir         <= 16'h0000;
            r_cnt        <= 8'h00;
            r_fault      <= 1'b0;
            r_rd         <= 2'b00;
            r_rs         <= 2'b00;
            r_alu_func   <= 4'h0;
            r_alu_in_sel <= 1'b0;
            r_imm        <= 8'h00;
            r_pc_op      <= PC_HOLD;
        end else begin
            if ((r_state != ST_FWAIT && w_next == ST_FWAIT) ||
                (r_state != ST_AWAIT && w_next == ST_AWAIT)) begin
                r_cnt <= 8'h00;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_state == ST_FWAIT && ins_valid) begin
                r_ir <= ins;
            end

            if (r_state == ST_DECODE) begin
                r_rd         <= r_ir[11:10];
                r_rs         <= r_ir[9:8];
                r_alu_func   <= w_alu_func;
                r_alu_in_sel <= w_alu_in_sel;
                r_imm        <= r_ir[7:0];
                case (w_cls)
                    CLS_JMP:  r_pc_op <= PC_LOAD;
                    CLS_JR:   r_pc_op <= PC_REL;
                    CLS_HALT: r_pc_op <= PC_HOLD;
                    default:  r_pc_op <= PC_INC;
                endcase
                if (w_illegal) r_fault <= 1'b1;
            end

            if ((r_state == ST_FWAIT || r_state == ST_AWAIT) && w_next == ST_HALT) begin
                r_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        ins_req     = 1'b0;
        en_in_rf    = 1'b0;
        reg_en      = 4'b0000;
        en_pc_pulse = 1'b0;
        pc_ctrl     = PC_HOLD;
        busy        = 1'b1;
        halted      = 1'b0;
        case (r_state)
            ST_IDLE:  busy = 1'b0;
            ST_FETCH: ins_req = 1'b1;
            ST_EXEC:  en_in_rf = 1'b1;
            ST_WB: begin
                reg_en  = onehot4(r_rd);
                pc_ctrl = r_pc_op;
            end
            ST_PCUPD: begin
                en_pc_pulse = 1'b1;
                pc_ctrl     = r_pc_op;
            end
            ST_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd          = r_rd;
    assign rs          = r_rs;
    assign alu_func    = r_alu_func;
    assign alu_in_sel  = r_alu_in_sel;
    assign offset      = r_imm;
    assign offset_addr = r_imm;
    assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// ============================================================================
//  Module  : tb_cpu_ctrl
//  Brief   : Directed scoreboard bench for cpu_ctrl strobes and status.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_ctrl;

    localparam int c_ev_req = 0;
    localparam int c_ev_exe = 1;
    localparam int c_ev_wb  = 2;
    localparam int c_ev_pc  = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ins_req;
    logic        ins_valid;
    logic [15:0] ins;
    logic        alu_done;
    logic        en_in_rf;
    logic [3:0]  reg_en;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        alu_in_sel;
    logic [3:0]  alu_func;
    logic [7:0]  offset;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic        busy;
    logic        halted;
    logic        fault;

    int  n_checks = 0;
    int  n_errors = 0;
    ev_t sb[$];

    cpu_ctrl #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ins_req     (ins_req),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .alu_done    (alu_done),
        .en_in_rf    (en_in_rf),
        .reg_en      (reg_en),
        .rd          (rd),
        .rs          (rs),
        .alu_in_sel  (alu_in_sel),
        .alu_func    (alu_func),
        .offset      (offset),
        .en_pc_pulse (en_pc_pulse),
        .pc_ctrl     (pc_ctrl),
        .offset_addr (offset_addr),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk_ev(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        return e;
    endfunction

    function automatic ev_t exp_exe(input logic [1:0] d, input logic [1:0] s,
                                    input logic [3:0] f, input logic sel, input logic [7:0] imm);
        return mk_ev(c_ev_exe, {15'b0, d, s, f, sel, imm});
    endfunction

    function automatic logic [63:0] all_outs();
        return {27'b0, ins_req, en_in_rf, reg_en, rd, rs, alu_in_sel, alu_func, offset,
                en_pc_pulse, pc_ctrl, offset_addr, busy, halted, fault};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every strobe cycle is matched in order against the expected-event queue
    always @(negedge clk) begin
        int  n;
        ev_t obs;
        ev_t exp;
        if (!rst) begin
            n = int'(ins_req) + int'(en_in_rf) + int'(|reg_en) + int'(en_pc_pulse);
            chk("strobe_exclusive", 64'(n <= 1), 64'd1);
            if (n != 0) begin
                if (ins_req)       obs = mk_ev(c_ev_req, 32'h0);
                else if (en_in_rf) obs = mk_ev(c_ev_exe, {15'b0, rd, rs, alu_func, alu_in_sel, offset});
                else if (|reg_en)  obs = mk_ev(c_ev_wb, {28'b0, reg_en});
                else               obs = mk_ev(c_ev_pc, {22'b0, pc_ctrl, offset_addr});
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $error("FAIL unexpected_event: observed kind %0d val %h, expected none", obs.kind, obs.val);
                end else begin
                    exp = sb.pop_front();
                    assert (obs.kind === exp.kind && obs.val === exp.val) else begin
                        n_errors++;
                        $error("FAIL event: observed kind %0d val %h expected kind %0d val %h",
                               obs.kind, obs.val, exp.kind, exp.val);
                    end
                end
            end
        end
    end

    task automatic wait_strobe(input int which, input int budget);
        bit seen;
        seen = (which == 0) ? ins_req : en_in_rf;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? ins_req : en_in_rf;
        end
        chk($sformatf("wait_strobe_%0d", which), 64'(seen), 64'd1);
    endtask

    task automatic do_reset();
        chk("sb_empty_before_reset", 64'(sb.size()), 64'd0);
        rst = 1'b1; start = 1'b0; ins_valid = 1'b0; ins = 16'h0; alu_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // junk=1 also drives a HALT word during the FETCH cycle, which must be ignored
    task automatic fetch(input logic [15:0] w, input int dly, input bit junk);
        wait_strobe(0, 40);
        if (junk) begin
            ins = 16'hF000; ins_valid = 1'b1;
            @(negedge clk);
            ins_valid = 1'b0;
            repeat (dly - 1) @(negedge clk);
        end else begin
            repeat (dly) @(negedge clk);
        end
        ins = w; ins_valid = 1'b1;
        @(negedge clk);
        ins_valid = 1'b0; ins = 16'h0;
    endtask

    task automatic do_alu(input int dly);
        wait_strobe(1, 40);
        repeat (dly) @(negedge clk);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed no completion, expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        do_reset();

        // ADD r1,r0 then LDI, JMP, JR, SUB with done on terminal cycle, HALT
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        pulse_start();
        sb.push_back(exp_exe(2'd1, 2'd0, 4'b0001, 1'b0, 8'h00));
        sb.push_back(mk_ev(c_ev_wb, 32'h2));
        sb.push_back(mk_ev(c_ev_pc, {22'b0, 2'b01, 8'h00}));
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        fetch(16'h1400, 2, 1'b0);
        do_alu(3);

        sb.push_back(exp_exe(2'd3, 2'd0, 4'b1000, 1'b1, 8'h5A));
        sb.push_back(mk_ev(c_ev_wb, 32'h8));
        sb.push_back(mk_ev(c_ev_pc, {22'b0, 2'b01, 8'h5A}));
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        fetch(16'h8C5A, 2, 1'b1);
        do_alu(1);

        sb.push_back(mk_ev(c_ev_pc, {22'b0, 2'b10, 8'h20}));
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        fetch(16'hC020, 2, 1'b0);
        chk("jmp_pc_pulse_t+1", 64'(en_pc_pulse), 64'd0);
        @(negedge clk);
        chk("jmp_pc_pulse_t+2", {62'b0, en_pc_pulse, 1'b0} | 64'(pc_ctrl) << 8 | 64'(offset_addr) << 16,
            {62'b0, 1'b1, 1'b0} | 64'(2'b10) << 8 | 64'(8'h20) << 16);

        sb.push_back(mk_ev(c_ev_pc, {22'b0, 2'b11, 8'hF0}));
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        fetch(16'hD0F0, 1, 1'b0);

        sb.push_back(exp_exe(2'd2, 2'd1, 4'b0010, 1'b0, 8'h00));
        sb.push_back(mk_ev(c_ev_wb, 32'h4));
        sb.push_back(mk_ev(c_ev_pc, {22'b0, 2'b01, 8'h00}));
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        fetch(16'h2900, 3, 1'b0);
        do_alu(16);
        chk("terminal_done_no_fault", {62'b0, fault, halted}, 64'd0);

        fetch(16'hF000, 1, 1'b0);
        @(negedge clk);
        chk("halt_status", {61'b0, halted, busy, fault}, 64'b100);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("halt_absorbs_start", 64'(halted), 64'd1);

        // Illegal opcode: fault, PC increments, execution continues
        do_reset();
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        pulse_start();
        sb.push_back(mk_ev(c_ev_pc, {22'b0, 2'b01, 8'h00}));
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        fetch(16'hA000, 1, 1'b0);
        @(negedge clk);
        chk("illegal_fault", {61'b0, fault, busy, halted}, 64'b110);
        sb.push_back(exp_exe(2'd1, 2'd0, 4'b0001, 1'b0, 8'h00));
        sb.push_back(mk_ev(c_ev_wb, 32'h2));
        sb.push_back(mk_ev(c_ev_pc, {22'b0, 2'b01, 8'h00}));
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        fetch(16'h1400, 1, 1'b0);
        do_alu(2);
        repeat (3) @(negedge clk);

        // AWAIT timeout
        do_reset();
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        pulse_start();
        sb.push_back(exp_exe(2'd2, 2'd0, 4'b0001, 1'b0, 8'h00));
        fetch(16'h1800, 1, 1'b0);
        wait_strobe(1, 40);
        repeat (16) @(negedge clk);
        chk("await_last_cycle", {62'b0, fault, halted}, 64'd0);
        @(negedge clk);
        chk("await_timeout", {61'b0, fault, halted, busy}, 64'b110);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("timeout_absorbing", {62'b0, fault, halted}, 64'b11);

        // FWAIT timeout
        do_reset();
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        pulse_start();
        wait_strobe(0, 40);
        repeat (16) @(negedge clk);
        chk("fwait_last_cycle", {62'b0, fault, halted}, 64'd0);
        @(negedge clk);
        chk("fwait_timeout", {62'b0, fault, halted}, 64'b11);

        // Asynchronous reset in the middle of AWAIT
        do_reset();
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        pulse_start();
        sb.push_back(exp_exe(2'd3, 2'd0, 4'b0001, 1'b0, 8'h00));
        fetch(16'h1C00, 1, 1'b0);
        wait_strobe(1, 40);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 64'd0);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {62'b0, busy, halted}, 64'd0);
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        pulse_start();
        sb.push_back(exp_exe(2'd0, 2'd3, 4'b0101, 1'b0, 8'h00));
        sb.push_back(mk_ev(c_ev_wb, 32'h1));
        sb.push_back(mk_ev(c_ev_pc, {22'b0, 2'b01, 8'h00}));
        sb.push_back(mk_ev(c_ev_req, 32'h0));
        fetch(16'h5300, 2, 1'b0);
        do_alu(1);
        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Control unit for the 16-bit CPU datapath: fetches an instruction word, decodes it, and drives the datapath control strobes (register select, ALU function and input select, execute enable, write enable, PC update).
- Consumes the datapath's completion pulse `en_out` and sequences one instruction at a time.
- Sits between instruction memory and the datapath; it initiates every datapath transaction.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for `ins_valid` or `alu_done` before declaring a fault.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin execution from IDLE; ignored in every other state.
- `ins_req` out 1: one-cycle instruction fetch strobe (memory addresses with datapath `pc_out`).
- `ins_valid` in 1: instruction word valid.
- `ins` in 16: instruction word.
- `alu_done` in 1: datapath `en_out`, the ALU completion pulse.
- `en_in_rf` out 1: one-cycle execute strobe into the register file.
- `reg_en` out 4: one-hot register write enable.
- `rd` out 2: destination/A register select.
- `rs` out 2: source/B register select.
- `alu_in_sel` out 1: 0 = rs operand, 1 = immediate.
- `alu_func` out 4: ALU function code.
- `offset` out 8: immediate operand.
- `en_pc_pulse` out 1: one-cycle PC update strobe.
- `pc_ctrl` out 2: PC operation.
- `offset_addr` out 8: PC jump target or displacement.
- `busy` out 1: high in any state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `fault` out 1: sticky timeout or illegal-opcode flag.

Behaviour:
- Instruction format:
  - `[15:12]` opcode.
  - `[11:10]` rd.
  - `[9:8]` rs.
  - `[7:0]` imm; drives both `offset` and `offset_addr`.
- Opcodes:
  - 0000 NOP.
  - 0001..0111 reg-reg ALU op: `alu_func`={0,op[2:0]}, `alu_in_sel`=0.
  - 1000 LDI: ALU_PASSB, sel=1.
  - 1001 ADDI: ALU_ADD, sel=1.
  - 1100 JMP: `pc_ctrl`=PC_LOAD.
  - 1101 JR: `pc_ctrl`=PC_REL.
  - 1111 HALT.
  - All other opcodes are illegal: set `fault`, then behave as NOP.
- `pc_ctrl` encoding: 00 hold, 01 increment, 10 load `offset_addr`, 11 add sign-extended `offset_addr`.
- Reset (asynchronous): state IDLE; every output 0; IR, timeout counter and `fault` cleared. Reset mid-instruction abandons it, so no `reg_en` or `en_pc_pulse` is issued.
- FSM, one state per cycle unless stated:
  - IDLE: on `start` -> FETCH.
  - FETCH: `ins_req`=1 for exactly one cycle -> FWAIT.
  - FWAIT:
    - On `ins_valid`, latch `ins` into IR -> DECODE.
    - Counter reaching TIMEOUT -> set `fault`, go HALT.
    - `ins_valid` in the FETCH cycle itself is ignored.
  - DECODE: register `rd`, `rs`, `alu_func`, `alu_in_sel`, `offset`, `offset_addr` from IR. These stay stable until the next DECODE.
    - ALU/LDI/ADDI -> EXEC.
    - JMP/JR/NOP/illegal -> PCUPD.
    - HALT -> HALT.
  - EXEC: `en_in_rf`=1 for one cycle -> AWAIT.
  - AWAIT:
    - On `alu_done` -> WB.
    - TIMEOUT reached -> set `fault`, go HALT.
    - `alu_done` arriving in any other state is ignored.
    - `alu_done` in the same cycle as the timeout terminal count counts as done; no fault.
  - WB: `reg_en`=onehot(rd) for one cycle; `pc_ctrl` set to 01 -> PCUPD.
  - PCUPD: `en_pc_pulse`=1 for one cycle with `pc_ctrl` (01 for NOP/ALU/illegal, 10 JMP, 11 JR) -> FETCH.
  - HALT: absorbing until `rst`; `halted`=1; `start` ignored.
- Timeout counter: cleared on entry to FWAIT and AWAIT; saturates; 8 bits wide, so TIMEOUT ≤ 255.
- Strobes: `ins_req`, `en_in_rf`, `en_pc_pulse` and `reg_en` are never asserted simultaneously.
- Minimum latency from DECODE to next FETCH:
  - ALU instruction: 4 cycles plus datapath latency.
  - Jump: 1 cycle.

Decomposition:
- Package `cpu_pkg` holds:
  - opcode constants;
  - ALU function codes ALU_ADD=0001, ALU_SUB=0010, ALU_AND=0011, ALU_OR=0100, ALU_XOR=0101, ALU_SHL=0110, ALU_SHR=0111, ALU_PASSB=1000;
  - PC_HOLD/INC/LOAD/REL;
  - the FSM state enum.
- Sub-module `ctrl_decode`: purely combinational opcode -> {`alu_func`, `alu_in_sel`, class, illegal}. The FSM, IR and counter live in `cpu_ctrl`.

Test Plan:
- ADD: reset, `start`, `ins`=0x1400 with `ins_valid` 2 cycles after `ins_req`, `alu_done` 3 cycles after `en_in_rf`. Required:
  - `rd`=1, `rs`=0, `alu_func`=0001, `alu_in_sel`=0;
  - `reg_en`=0010 one cycle;
  - then `en_pc_pulse` with `pc_ctrl`=01;
  - then `ins_req` again.
- LDI: `ins`=0x8C5A. Required:
  - `alu_in_sel`=1, `offset`=0x5A, `alu_func`=1000, `rd`=3;
  - `reg_en`=1000.
- JMP: `ins`=0xC020. Required:
  - no `en_in_rf`, no `reg_en`;
  - `en_pc_pulse` with `pc_ctrl`=10, `offset_addr`=0x20, exactly 2 cycles after `ins_valid`.
- Timeout:
  - No `alu_done` after `en_in_rf`: at TIMEOUT=16 cycles `fault`=1 and `halted`=1; later `alu_done` and `start` ignored.
  - `alu_done` on the terminal cycle: no fault.
- HALT/illegal:
  - `ins`=0xF000: `halted`=1, `busy`=0, `fault`=0.
  - `ins`=0xA000: `fault`=1, PC increments, fetch continues.
- Reset mid-AWAIT: assert `rst` asynchronously. Required:
  - all outputs 0 immediately, state IDLE, no `reg_en` pulse;
  - a subsequent `start` fetches normally.
